// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the 32-bit datapath ALU: steps the operand,
// execute and writeback strobes for one opcode, with a stretched EXEC window for MUL/DIV.
module alu_op_sequencer #(
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [3:0]  op,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] alu_ctrl,
    output logic        a_out,
    output logic        y_in,
    output logic        b_out,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        rz_in,
    output logic        lo_in,
    output logic        hi_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_ERR
    } state_e;

    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_LAST  = 4'd11;
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_muldiv;

    assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no path leaves a latch behind.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op <= OP_LAST) begin
                        op_d    = op;
                        state_d = S_LOAD_A;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_LOAD_A: begin
                state_d = S_EXEC;
                cnt_d   = CNT_LOAD;
            end
            S_EXEC: begin
                if (!is_muldiv || (cnt_q == 4'd0)) begin
                    state_d = S_WB_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB_LO: state_d = is_muldiv ? S_WB_HI : S_IDLE;
            S_WB_HI: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs only: nothing here looks at start or op directly.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        alu_ctrl  = '0;
        a_out     = 1'b0;
        y_in      = 1'b0;
        b_out     = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        rz_in     = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                a_out = 1'b1;
                y_in  = 1'b1;
            end
            S_EXEC: begin
                b_out    = 1'b1;
                alu_ctrl = 12'd1 << op_q;
                z_in     = !is_muldiv || (cnt_q == 4'd0);
            end
            S_WB_LO: begin
                zlow_out = 1'b1;
                rz_in    = !is_muldiv;
                lo_in    = is_muldiv;
                done     = !is_muldiv;
            end
            S_WB_HI: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances (MULDIV_CYCLES 4, 1, 15) checked every
// cycle against a schedule-based reference, plus a directed vector table for the first.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [11:0] alu;
        logic [8:0]  strb;   // a_out,y_in,b_out,z_in,zlow_out,zhigh_out,rz_in,lo_in,hi_in
    } out_t;

    typedef struct {
        logic       clr;
        logic       start;
        logic [3:0] op;
        out_t       exp;
    } vec_t;

    localparam int NI = 3;

    logic       clock   = 1'b0;
    logic       clear_n = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] op      = 4'd0;

    always #5 clock = ~clock;

    out_t act [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic        busy, done, err;
        logic [11:0] alu_ctrl;
        logic        a_out, y_in, b_out, z_in, zlow_out, zhigh_out, rz_in, lo_in, hi_in;

        alu_op_sequencer #(
            .MULDIV_CYCLES((gi == 0) ? 4 : ((gi == 1) ? 1 : 15))
        ) dut (
            .clock     (clock),
            .clear_n   (clear_n),
            .start     (start),
            .op        (op),
            .busy      (busy),
            .done      (done),
            .err       (err),
            .alu_ctrl  (alu_ctrl),
            .a_out     (a_out),
            .y_in      (y_in),
            .b_out     (b_out),
            .z_in      (z_in),
            .zlow_out  (zlow_out),
            .zhigh_out (zhigh_out),
            .rz_in     (rz_in),
            .lo_in     (lo_in),
            .hi_in     (hi_in)
        );

        assign act[gi] = {busy, done, err, alu_ctrl,
                          a_out, y_in, b_out, z_in, zlow_out, zhigh_out, rz_in, lo_in, hi_in};
    end

    int   errors = 0;
    int   checks = 0;
    out_t sched [NI][20];
    int   rd [NI];
    int   len [NI];
    out_t prev [NI];
    int   model_done [NI];
    int   dut_done [NI];
    vec_t tbl [17];

    function automatic int mc(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic out_t fr(input logic b, input logic d, input logic e,
                                input logic [11:0] alu, input logic [8:0] s);
        out_t f;
        f.busy = b; f.done = d; f.err = e; f.alu = alu; f.strb = s;
        return f;
    endfunction

    function automatic vec_t mk(input logic c, input logic s, input logic [3:0] o,
                                input logic b, input logic d, input logic e,
                                input logic [11:0] alu, input logic [8:0] st);
        vec_t v;
        v.clr = c; v.start = s; v.op = o; v.exp = fr(b, d, e, alu, st);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push(input int k, input out_t f);
        sched[k][len[k]] = f;
        len[k]++;
    endtask

    // Reference: an accepted request becomes the list of per-cycle output frames it produces.
    task automatic accept(input int k, input logic [3:0] o);
        int n;
        bit md;
        rd[k]  = 0;
        len[k] = 0;
        if (o > 4'd11) begin
            push(k, fr(1, 0, 1, 12'h000, 9'h000));
        end else begin
            md = (o == 4'd2) || (o == 4'd3);
            n  = md ? mc(k) : 1;
            push(k, fr(1, 0, 0, 12'h000, 9'h180));
            for (int i = 0; i < n; i++)
                push(k, fr(1, 0, 0, 12'd1 << o, (i == n - 1) ? 9'h060 : 9'h040));
            if (md) begin
                push(k, fr(1, 0, 0, 12'h000, 9'h012));
                push(k, fr(1, 1, 0, 12'h000, 9'h009));
            end else begin
                push(k, fr(1, 1, 0, 12'h000, 9'h014));
            end
        end
    endtask

    task automatic cyc(input logic c, input logic s, input logic [3:0] o);
        out_t e;
        int   nb, nw;
        clear_n = c;
        start   = s;
        op      = o;
        @(posedge clock);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (!c) begin
                rd[k]  = 0;
                len[k] = 0;
                e      = '0;
            end else begin
                if (!prev[k].busy && s) accept(k, o);
                if (rd[k] < len[k]) begin
                    e = sched[k][rd[k]];
                    rd[k]++;
                end else begin
                    e = '0;
                end
            end
            if (e.done) model_done[k]++;
            if (act[k].done) dut_done[k]++;
            check($sformatf("out_inst%0d", k), {8'h0, act[k]}, {8'h0, e});
            nb = $countones({act[k].strb[8], act[k].strb[6], act[k].strb[4], act[k].strb[3]});
            nw = $countones(act[k].strb[2:0]);
            check($sformatf("bus_excl_inst%0d", k), 32'(nb > 1), 32'd0);
            check($sformatf("wen_excl_inst%0d", k), 32'(nw > 1), 32'd0);
            prev[k] = e;
        end
    endtask

    initial begin
        bit any_busy;
        int guard;

        for (int k = 0; k < NI; k++) begin
            rd[k] = 0; len[k] = 0; prev[k] = '0; model_done[k] = 0; dut_done[k] = 0;
        end

        // Directed per-cycle vectors for the MULDIV_CYCLES=4 instance: ADD, illegal op, busy drop.
        tbl[0]  = mk(0, 0, 4'd0,  0, 0, 0, 12'h000, 9'h000);
        tbl[1]  = mk(1, 1, 4'd0,  1, 0, 0, 12'h000, 9'h180);
        tbl[2]  = mk(1, 0, 4'd0,  1, 0, 0, 12'h001, 9'h060);
        tbl[3]  = mk(1, 0, 4'd0,  1, 1, 0, 12'h000, 9'h014);
        tbl[4]  = mk(1, 0, 4'd0,  0, 0, 0, 12'h000, 9'h000);
        tbl[5]  = mk(1, 1, 4'd13, 1, 0, 1, 12'h000, 9'h000);
        tbl[6]  = mk(1, 0, 4'd11, 0, 0, 0, 12'h000, 9'h000);
        tbl[7]  = mk(1, 1, 4'd11, 1, 0, 0, 12'h000, 9'h180);
        tbl[8]  = mk(1, 0, 4'd0,  1, 0, 0, 12'h800, 9'h060);
        tbl[9]  = mk(1, 0, 4'd0,  1, 1, 0, 12'h000, 9'h014);
        tbl[10] = mk(1, 0, 4'd0,  0, 0, 0, 12'h000, 9'h000);
        tbl[11] = mk(1, 1, 4'd8,  1, 0, 0, 12'h000, 9'h180);
        tbl[12] = mk(1, 1, 4'd9,  1, 0, 0, 12'h100, 9'h060);
        tbl[13] = mk(1, 1, 4'd9,  1, 1, 0, 12'h000, 9'h014);
        tbl[14] = mk(1, 1, 4'd9,  0, 0, 0, 12'h000, 9'h000);
        tbl[15] = mk(1, 0, 4'd9,  0, 0, 0, 12'h000, 9'h000);
        tbl[16] = mk(1, 0, 4'd0,  0, 0, 0, 12'h000, 9'h000);

        cyc(0, 0, 4'd0);
        cyc(0, 0, 4'd0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].clr, tbl[i].start, tbl[i].op);
            check($sformatf("vec%0d", i), {8'h0, act[0]}, {8'h0, tbl[i].exp});
        end

        // MUL with a 4-cycle window: alu_ctrl held cycles 2-5, z_in only on the last.
        cyc(1, 1, 4'd2);
        check("mul_load", {8'h0, act[0]}, {8'h0, fr(1, 0, 0, 12'h000, 9'h180)});
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 4'd0);
            check($sformatf("mul_exec%0d", i), {8'h0, act[0]},
                  {8'h0, fr(1, 0, 0, 12'h004, (i == 3) ? 9'h060 : 9'h040)});
        end
        cyc(1, 0, 4'd0);
        check("mul_wb_lo", {8'h0, act[0]}, {8'h0, fr(1, 0, 0, 12'h000, 9'h012)});
        cyc(1, 0, 4'd0);
        check("mul_wb_hi", {8'h0, act[0]}, {8'h0, fr(1, 1, 0, 12'h000, 9'h009)});
        cyc(1, 0, 4'd0);
        check("mul_idle", {8'h0, act[0]}, 32'h0);
        for (int k = 0; k < NI; k++) cyc(1, 0, 4'd0);

        // Reset held two cycles in the middle of a DIV window, start high throughout.
        cyc(1, 1, 4'd3);
        cyc(1, 0, 4'd0);
        cyc(1, 0, 4'd0);
        cyc(0, 1, 4'd5);
        check("rst_mid0", {8'h0, act[0]}, 32'h0);
        cyc(0, 1, 4'd5);
        check("rst_mid1", {8'h0, act[0]}, 32'h0);
        cyc(1, 0, 4'd0);
        check("rst_after", {8'h0, act[0]}, 32'h0);
        cyc(1, 1, 4'd0);
        check("rst_restart", {8'h0, act[0]}, {8'h0, fr(1, 0, 0, 12'h000, 9'h180)});
        cyc(1, 0, 4'd0);
        check("rst_restart_exec", {8'h0, act[0]}, {8'h0, fr(1, 0, 0, 12'h001, 9'h060)});
        cyc(1, 0, 4'd0);
        cyc(1, 0, 4'd0);

        // All twelve ops in turn; every instance is drained before the next request.
        for (int o = 0; o < 12; o++) begin
            cyc(1, 1, 4'(o));
            guard = 0;
            do begin
                cyc(1, 0, 4'($urandom_range(0, 15)));
                any_busy = 1'b0;
                for (int k = 0; k < NI; k++) any_busy |= act[k].busy;
                guard++;
            end while (any_busy && guard < 25);
            check($sformatf("drain_op%0d", o), 32'(any_busy), 32'd0);
        end

        // Randomized traffic: mostly start high, random ops, occasional reset.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)));
        end

        for (int k = 0; k < NI; k++)
            check($sformatf("done_count_inst%0d", k), 32'(dut_done[k]), 32'(model_done[k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
